// File: rtl/bus_hub_pkg.sv
// rtl/bus_hub_pkg.sv - shared FSM state type and default parameters for bus_hub
//
// Purpose: holds the bus_hub FSM state enum and the default parameter
// constants, so the top and the bench build from the same values.
// Ports: none (package).
package bus_hub_pkg;

    localparam int DEF_AW   = 12;
    localparam int DEF_DW   = 16;
    localparam int DEF_CHW  = 4;
    localparam int DEF_NCH  = 16;
    localparam int DEF_SYNC = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WCOMMIT = 2'd1,
        READ    = 2'd2
    } state_t;

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - SYNC-deep synchroniser with rise/fall edge detect
//
// Purpose: brings one asynchronous strobe into the clk domain and flags its
// edges against a further delayed copy of the last stage.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   d         - asynchronous input strobe
//   q         - synchronised level (last synchroniser stage)
//   rise/fall - one-cycle edge flags of q
// Every flop resets to RST_VAL. With RST_VAL=1, a strobe that is already high
// when reset releases never produces a rise.
module bus_sync #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] sh;
    logic            dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= {SYNC{RST_VAL}};
            dly <= RST_VAL;
        end else begin
            sh  <= {sh[SYNC-2:0], d};
            dly <= sh[SYNC-1];
        end
    end

    assign q    = sh[SYNC-1];
    assign rise = sh[SYNC-1] & ~dly;
    assign fall = ~sh[SYNC-1] & dly;

endmodule

// File: rtl/bus_hub.sv
// rtl/bus_hub.sv - asynchronous MCU bus to per-channel register hub
//
// Purpose: decodes an asynchronous MCU RD/WR bus into NCH channels. Writes
// latch into wrdata with a one-cycle wr_stb; reads drive the selected
// channel's rddata onto DATA and pulse rd_stb when RD falls.
// Optional feature macro: BUS_HUB_ERR_EN adds a sticky err flag and a
// saturating 8-bit err_cnt for unmapped accesses and RD/WR conflicts.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   ADDR, RD, WR      - asynchronous MCU address and strobes
//   DATA              - MCU data bus, driven only while raw RD is high
//   cs                - combinational one-hot channel decode of ADDR
//   wr_stb, rd_stb    - one-cycle per-channel write / read-pop pulses
//   sub_addr          - ADDR low bits of the last committed access
//   rddata, wrdata    - per-channel data, channel k at [k*DW +: DW]
//   err, err_cnt      - error flag and counter (BUS_HUB_ERR_EN only)
module bus_hub
    import bus_hub_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int CHW  = DEF_CHW,
    parameter int NCH  = DEF_NCH,
    parameter int SYNC = DEF_SYNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ADDR,
    input  logic              RD,
    input  logic              WR,
    inout  wire  [DW-1:0]     DATA,
    output logic [NCH-1:0]    cs,
    output logic [NCH-1:0]    wr_stb,
    output logic [NCH-1:0]    rd_stb,
    output logic [AW-CHW-1:0] sub_addr,
    input  logic [NCH*DW-1:0] rddata,
    output logic [NCH*DW-1:0] wrdata
`ifdef BUS_HUB_ERR_EN
    ,
    output logic              err,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [CHW:0] NCH_LIM = (CHW+1)'(NCH);

    state_t state, state_d;

    logic rd_s, rd_rise, rd_fall;
    logic wr_s, wr_rise, wr_fall;
    logic unused_wr;

    logic [CHW-1:0]    ch;
    logic [AW-CHW-1:0] sub;
    logic              addr_mapped;

    logic [CHW-1:0]    cap_ch;
    logic [AW-CHW-1:0] cap_sub;
    logic [DW-1:0]     cap_data;
    logic              cap_mapped;

    logic [DW-1:0] rd_sel, rd_hold;
    logic          cap_en, wcommit, rcommit;

    bus_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_rd_sync (
        .clk (clk), .rst (rst), .d (RD),
        .q   (rd_s), .rise (rd_rise), .fall (rd_fall)
    );

    bus_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_wr_sync (
        .clk (clk), .rst (rst), .d (WR),
        .q   (wr_s), .rise (wr_rise), .fall (wr_fall)
    );

    // Only the WR rise starts anything; its level and fall carry no action.
    assign unused_wr = wr_s ^ wr_fall;

    assign ch          = ADDR[AW-1:AW-CHW];
    assign sub         = ADDR[AW-CHW-1:0];
    assign addr_mapped = ({1'b0, ch} < NCH_LIM);
    assign cap_mapped  = ({1'b0, cap_ch} < NCH_LIM);

    always_comb begin
        cs     = '0;
        rd_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            cs[k] = (ch == CHW'(k));
            if (ch == CHW'(k)) rd_sel = rddata[k*DW +: DW];
        end
    end

    assign DATA = RD ? rd_hold : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        cap_en  = 1'b0;
        wcommit = 1'b0;
        rcommit = 1'b0;
        case (state)
            IDLE: begin
                // A rd rise implies rd_s=1, so a simultaneous wr rise is a
                // conflict and falls through to the read.
                if (rd_rise) begin
                    state_d = READ;
                    cap_en  = 1'b1;
                end else if (wr_rise && !rd_s) begin
                    state_d = WCOMMIT;
                    cap_en  = 1'b1;
                end
            end
            WCOMMIT: begin
                state_d = IDLE;
                wcommit = cap_mapped;
            end
            READ: begin
                if (rd_fall) begin
                    state_d = IDLE;
                    rcommit = cap_mapped;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hold  <= '0;
            cap_ch   <= '0;
            cap_sub  <= '0;
            cap_data <= '0;
            wrdata   <= '0;
            sub_addr <= '0;
            wr_stb   <= '0;
            rd_stb   <= '0;
        end else begin
            rd_hold <= rd_sel;
            wr_stb  <= '0;
            rd_stb  <= '0;
            if (cap_en) begin
                cap_ch   <= ch;
                cap_sub  <= sub;
                cap_data <= DATA;
            end
            if (wcommit || rcommit) sub_addr <= cap_sub;
            for (int k = 0; k < NCH; k++) begin
                if (cap_ch == CHW'(k)) begin
                    if (wcommit) begin
                        wrdata[k*DW +: DW] <= cap_data;
                        wr_stb[k]          <= 1'b1;
                    end
                    if (rcommit) rd_stb[k] <= 1'b1;
                end
            end
        end
    end

`ifdef BUS_HUB_ERR_EN
    logic err_evt, err_clr;

    always_comb begin
        err_evt = 1'b0;
        err_clr = 1'b0;
        case (state)
            IDLE: begin
                if (wr_rise && rd_s)       err_evt = 1'b1;
                if (rd_rise && !addr_mapped) err_evt = 1'b1;
            end
            WCOMMIT: begin
                // The top channel, when unmapped, doubles as the error-clear
                // register.
                if (!cap_mapped) begin
                    if (cap_ch == '1) err_clr = 1'b1;
                    else              err_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_evt) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_hub.sv
// tb/tb_bus_hub.sv - self-checking bench for bus_hub
module tb_bus_hub;

    localparam int AW = 12, DW = 16, CHW = 4, NCH = 8, SYNC = 2;
    localparam int EV_WR = 0, EV_RSTB = 1, EV_ERR = 2, EV_CLR = 3;

    typedef struct {
        int          cyc;
        int          kind;
        int          ch;
        logic [15:0] data;
        logic [7:0]  sub;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    wire  [DW-1:0]     data_bus;
    logic [DW-1:0]     data_drv = '0;
    logic              data_oe = 1'b0;
    logic [NCH-1:0]    cs, wr_stb, rd_stb;
    logic [AW-CHW-1:0] sub_addr;
    logic [NCH*DW-1:0] rddata = '0;
    logic [NCH*DW-1:0] wrdata;
`ifdef BUS_HUB_ERR_EN
    logic              err;
    logic [7:0]        err_cnt;
`endif

    assign data_bus = data_oe ? data_drv : 'z;

    bus_hub #(.AW(AW), .DW(DW), .CHW(CHW), .NCH(NCH), .SYNC(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .ADDR     (addr),
        .RD       (rd),
        .WR       (wr),
        .DATA     (data_bus),
        .cs       (cs),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb),
        .sub_addr (sub_addr),
        .rddata   (rddata),
        .wrdata   (wrdata)
`ifdef BUS_HUB_ERR_EN
        ,
        .err      (err),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int wr3_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model: expected register file and error state, updated by
    // scheduled events that the stimulus tasks derive from the bus timing.
    logic [DW-1:0]     m_wrdata [NCH];
    logic [NCH-1:0]    m_wr_stb, m_rd_stb;
    logic [7:0]        m_sub;
    logic              m_err;
    int                m_cnt;
    logic [DW-1:0]     hold_exp;
    logic [NCH*DW-1:0] exp_wd;
    logic [NCH-1:0]    exp_cs;
    ev_t               evq[$];
    ev_t               keep_q[$];

    // The value on DATA is the selected channel's rddata as seen one edge ago.
    always @(posedge clk or posedge rst) begin
        if (rst) hold_exp <= '0;
        else begin
            int c;
            c = int'(addr[11:8]);
            hold_exp <= (c < NCH) ? rddata[c*DW +: DW] : '0;
        end
    end

    always @(negedge clk) begin
        int c;
        m_wr_stb = '0;
        m_rd_stb = '0;
        if (rst) begin
            for (int k = 0; k < NCH; k++) m_wrdata[k] = '0;
            m_sub = '0;
            m_err = 1'b0;
            m_cnt = 0;
            evq.delete();
        end else begin
            keep_q = {};
            foreach (evq[i]) begin
                if (evq[i].cyc == cyc) begin
                    case (evq[i].kind)
                        EV_WR: begin
                            m_wr_stb[evq[i].ch] = 1'b1;
                            m_wrdata[evq[i].ch] = evq[i].data;
                            m_sub = evq[i].sub;
                        end
                        EV_RSTB: begin
                            m_rd_stb[evq[i].ch] = 1'b1;
                            m_sub = evq[i].sub;
                        end
                        EV_ERR: begin
                            m_err = 1'b1;
                            if (m_cnt < 255) m_cnt++;
                        end
                        default: begin
                            m_err = 1'b0;
                            m_cnt = 0;
                        end
                    endcase
                end else begin
                    keep_q.push_back(evq[i]);
                end
            end
            evq = keep_q;
        end

        for (int k = 0; k < NCH; k++) exp_wd[k*DW +: DW] = m_wrdata[k];
        exp_cs = '0;
        c = int'(addr[11:8]);
        if (c < NCH) exp_cs[c] = 1'b1;

        chk("wr_stb", 128'(wr_stb), 128'(m_wr_stb));
        chk("rd_stb", 128'(rd_stb), 128'(m_rd_stb));
        chk("wrdata", 128'(wrdata), 128'(exp_wd));
        chk("sub_addr", 128'(sub_addr), 128'(m_sub));
        chk("cs", 128'(cs), 128'(exp_cs));
        if (rd)           chk("data_read", 128'(data_bus), 128'(hold_exp));
        else if (data_oe) chk("data_released", 128'(data_bus), 128'(data_drv));
`ifdef BUS_HUB_ERR_EN
        chk("err", 128'(err), 128'(m_err));
        chk("err_cnt", 128'(err_cnt), 128'(m_cnt));
`endif
        wr_pulses += $countones(wr_stb);
        rd_pulses += $countones(rd_stb);
        if (wr_stb[3] && wr3_cyc < 0) wr3_cyc = cyc;
    end

    task automatic start_write(input logic [11:0] a, input logic [15:0] d);
        int c0 = cyc;
        int ch = int'(a[11:8]);
        addr = a; data_drv = d; data_oe = 1'b1; wr = 1'b1;
        if (ch < NCH)     evq.push_back('{c0 + SYNC + 2, EV_WR, ch, d, a[7:0]});
        else if (ch == 15) evq.push_back('{c0 + SYNC + 2, EV_CLR, ch, d, a[7:0]});
        else              evq.push_back('{c0 + SYNC + 2, EV_ERR, ch, d, a[7:0]});
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        start_write(a, d);
        tick(6);
        wr = 1'b0;
        tick(6);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [15:0] v);
        int c0, c1;
        int ch = int'(a[11:8]);
        if (ch < NCH) rddata[ch*DW +: DW] = v;
        data_oe = 1'b0; addr = a; rd = 1'b1;
        c0 = cyc;
        if (ch >= NCH) evq.push_back('{c0 + SYNC + 1, EV_ERR, ch, 16'h0, a[7:0]});
        tick(2);
        chk("read_data_2clk", 128'(data_bus), 128'((ch < NCH) ? v : 16'h0));
        tick(4);
        rd = 1'b0; data_drv = 16'h0F0F; data_oe = 1'b1;
        c1 = cyc;
        if (ch < NCH) evq.push_back('{c1 + SYNC + 1, EV_RSTB, ch, 16'h0, a[7:0]});
        tick(6);
    endtask

    task automatic do_conflict(input logic [11:0] a, input logic [15:0] v);
        int c0, c1;
        int ch = int'(a[11:8]);
        rddata[ch*DW +: DW] = v;
        data_oe = 1'b0; addr = a; rd = 1'b1; wr = 1'b1;
        c0 = cyc;
        evq.push_back('{c0 + SYNC + 1, EV_ERR, ch, 16'h0, a[7:0]});
        tick(6);
        rd = 1'b0; wr = 1'b0; data_drv = 16'h3C3C; data_oe = 1'b1;
        c1 = cyc;
        evq.push_back('{c1 + SYNC + 1, EV_RSTB, ch, 16'h0, a[7:0]});
        tick(6);
    endtask

    initial begin
        int c0;
        tick(3);
        chk("reset_wrdata", 128'(wrdata), 128'(0));
        chk("reset_strobes", 128'({wr_stb, rd_stb}), 128'(0));
        chk("reset_sub_addr", 128'(sub_addr), 128'(0));
        rst = 1'b0;
        tick(6);

        // Write 0x305 <- A5A5
        wr_pulses = 0; wr3_cyc = -1;
        c0 = cyc;
        do_write(12'h305, 16'hA5A5);
        chk("write_wrdata3", 128'(wrdata[3*DW +: DW]), 128'(16'hA5A5));
        chk("write_sub_addr", 128'(sub_addr), 128'(8'h05));
        chk("write_pulses", 128'(wr_pulses), 128'(1));
        chk("write_latency", 128'(wr3_cyc - c0), 128'(4));

        // Read 0x700 -> 1234
        rd_pulses = 0;
        do_read(12'h700, 16'h1234);
        chk("read_pulses", 128'(rd_pulses), 128'(1));
        chk("read_sub_addr", 128'(sub_addr), 128'(8'h00));

        // Unmapped write to channel 10
        wr_pulses = 0;
        start_write(12'hA00, 16'h1111);
        tick(1);
        chk("unmapped_cs", 128'(cs), 128'(0));
        tick(5);
        wr = 1'b0;
        tick(6);
        chk("unmapped_pulses", 128'(wr_pulses), 128'(0));
        chk("unmapped_wrdata3", 128'(wrdata[3*DW +: DW]), 128'(16'hA5A5));
`ifdef BUS_HUB_ERR_EN
        chk("unmapped_err", 128'(err), 128'(1));
        chk("unmapped_err_cnt", 128'(err_cnt), 128'(1));
`endif

        // RD and WR together on channel 2
        wr_pulses = 0; rd_pulses = 0;
        do_conflict(12'h200, 16'hBEEF);
        chk("conflict_wr_pulses", 128'(wr_pulses), 128'(0));
        chk("conflict_rd_pulses", 128'(rd_pulses), 128'(1));
        chk("conflict_wrdata2", 128'(wrdata[2*DW +: DW]), 128'(0));
`ifdef BUS_HUB_ERR_EN
        chk("conflict_err_cnt", 128'(err_cnt), 128'(2));
`endif

        // Error clear through the unmapped top channel
        do_write(12'hF00, 16'h0000);
`ifdef BUS_HUB_ERR_EN
        chk("clear_err", 128'(err), 128'(0));
        chk("clear_err_cnt", 128'(err_cnt), 128'(0));
`endif

        // WR already high across reset release
        wr_pulses = 0;
        rst = 1'b1;
        addr = 12'h412; data_drv = 16'h7777; data_oe = 1'b1; wr = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        wr = 1'b0;
        tick(6);
        chk("straddle_pulses", 128'(wr_pulses), 128'(0));
        chk("straddle_wrdata", 128'(wrdata), 128'(0));
        do_write(12'h4AB, 16'hC3C3);
        chk("after_straddle_pulses", 128'(wr_pulses), 128'(1));
        chk("after_straddle_wrdata4", 128'(wrdata[4*DW +: DW]), 128'(16'hC3C3));
        chk("after_straddle_sub", 128'(sub_addr), 128'(8'hAB));

        // Reset landing in WCOMMIT aborts the write
        wr_pulses = 0;
        start_write(12'h1CD, 16'h5555);
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        wr = 1'b0;
        tick(6);
        chk("abort_pulses", 128'(wr_pulses), 128'(0));
        chk("abort_wrdata", 128'(wrdata), 128'(0));
        chk("abort_sub", 128'(sub_addr), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
